// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: pipeline control and load port in, PC and IF/ID register out.
// The master side drives control and load signals; the slave side is the fetch stage.
interface fetch_stage_if #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int IMEM_DEPTH = 64
);
    localparam int IDX_W = $clog2(IMEM_DEPTH);

    logic              stall_F;
    logic              flush_D;
    logic              pc_src_E;
    logic [ADDR_W-1:0] pc_target_E;
    logic              imem_we;
    logic [IDX_W-1:0]  imem_waddr;
    logic [DATA_W-1:0] imem_wdata;
    logic [ADDR_W-1:0] PC_F;
    logic [DATA_W-1:0] Instr_D;
    logic [ADDR_W-1:0] PC_D;
    logic [ADDR_W-1:0] PC_plus4_D;
    logic              valid_D;

    modport master (
        output stall_F, flush_D, pc_src_E, pc_target_E,
        output imem_we, imem_waddr, imem_wdata,
        input  PC_F, Instr_D, PC_D, PC_plus4_D, valid_D
    );

    modport slave (
        input  stall_F, flush_D, pc_src_E, pc_target_E,
        input  imem_we, imem_waddr, imem_wdata,
        output PC_F, Instr_D, PC_D, PC_plus4_D, valid_D
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, word-addressed imem (combinational read), IF/ID register.
// One-cycle fetch-to-decode latency; stall holds PC and IF/ID, redirect beats stall, flush beats stall.
module fetch_stage #(
    parameter int              ADDR_W     = 32,
    parameter int              DATA_W     = 32,
    parameter int              IMEM_DEPTH = 64,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.slave  bus
);
    localparam int IDX_W = $clog2(IMEM_DEPTH);

    logic [DATA_W-1:0] r_imem [IMEM_DEPTH];
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_instr_d;
    logic [ADDR_W-1:0] r_pc_d;
    logic [ADDR_W-1:0] r_pc_plus4_d;
    logic              r_valid_d;

    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_instr_f;
    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_pc_next;

    // Byte offset is dropped and the word index wraps modulo the memory depth.
    assign w_idx      = IDX_W'(r_pc >> 2);
    assign w_instr_f  = r_imem[w_idx];
    assign w_pc_plus4 = r_pc + ADDR_W'(4);

    always_comb begin
        w_pc_next = r_pc;
        if (bus.pc_src_E) begin
            w_pc_next = bus.pc_target_E & ~ADDR_W'(3);
        end else if (!bus.stall_F) begin
            w_pc_next = w_pc_plus4;
        end
    end

    // Load port is outside reset so memory can be preloaded while reset is held.
    always_ff @(posedge clk) begin
        if (bus.imem_we) begin
            r_imem[bus.imem_waddr] <= bus.imem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= '0;
            r_pc_plus4_d <= '0;
            r_valid_d    <= 1'b0;
        end else if (bus.flush_D) begin
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= '0;
            r_pc_plus4_d <= '0;
            r_valid_d    <= 1'b0;
        end else if (!bus.stall_F) begin
            r_instr_d    <= w_instr_f;
            r_pc_d       <= r_pc;
            r_pc_plus4_d <= w_pc_plus4;
            r_valid_d    <= 1'b1;
        end
    end

    assign bus.PC_F       = r_pc;
    assign bus.Instr_D    = r_instr_d;
    assign bus.PC_D       = r_pc_d;
    assign bus.PC_plus4_D = r_pc_plus4_d;
    assign bus.valid_D    = r_valid_d;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, sequential fetch, stall, redirect, priority, wrap, async reset.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    fetch_stage_if #(.ADDR_W(32), .DATA_W(32), .IMEM_DEPTH(64)) bus ();

    fetch_stage #(
        .ADDR_W(32), .DATA_W(32), .IMEM_DEPTH(64),
        .RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] instr, input logic [31:0] pcd,
                            input logic [31:0] pc4, input logic vld);
        chk({tag, ".Instr_D"},    bus.Instr_D,    instr);
        chk({tag, ".PC_D"},       bus.PC_D,       pcd);
        chk({tag, ".PC_plus4_D"}, bus.PC_plus4_D, pc4);
        chk({tag, ".valid_D"},    {31'd0, bus.valid_D}, {31'd0, vld});
    endtask

    task automatic load(input logic [5:0] a, input logic [31:0] d);
        bus.imem_we    = 1'b1;
        bus.imem_waddr = a;
        bus.imem_wdata = d;
        tick();
        bus.imem_we    = 1'b0;
    endtask

    task automatic ctrl(input logic stall, input logic flush, input logic src, input logic [31:0] tgt);
        bus.stall_F     = stall;
        bus.flush_D     = flush;
        bus.pc_src_E    = src;
        bus.pc_target_E = tgt;
    endtask

    initial begin
        rst = 1'b1;
        ctrl(1'b0, 1'b0, 1'b0, 32'h0);
        bus.imem_we    = 1'b0;
        bus.imem_waddr = '0;
        bus.imem_wdata = '0;
        #1 rst = 1'b0;
        #2;
        chk("reset.PC_F", bus.PC_F, 32'h0);
        chk_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);

        // Preload while reset is held.
        load(6'd0,  32'h11);
        load(6'd1,  32'h22);
        load(6'd2,  32'h33);
        load(6'd3,  32'h44);
        load(6'd4,  32'h55);
        load(6'd63, 32'hEE);
        chk("preload.PC_F", bus.PC_F, 32'h0);
        chk("preload.valid_D", {31'd0, bus.valid_D}, 32'h0);

        rst = 1'b1;
        tick();
        chk("seq0.PC_F", bus.PC_F, 32'h4);
        chk_ifid("seq0", 32'h11, 32'h0, 32'h4, 1'b1);
        tick();
        chk("seq1.PC_F", bus.PC_F, 32'h8);
        chk_ifid("seq1", 32'h22, 32'h4, 32'h8, 1'b1);

        // Stall two cycles at PC_F=8.
        ctrl(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        chk("stall0.PC_F", bus.PC_F, 32'h8);
        chk_ifid("stall0", 32'h22, 32'h4, 32'h8, 1'b1);
        tick();
        chk("stall1.PC_F", bus.PC_F, 32'h8);
        chk_ifid("stall1", 32'h22, 32'h4, 32'h8, 1'b1);
        ctrl(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("resume.PC_F", bus.PC_F, 32'hC);
        chk_ifid("resume", 32'h33, 32'h8, 32'hC, 1'b1);

        // Taken branch with misaligned target and flush.
        ctrl(1'b0, 1'b1, 1'b1, 32'h0000_000E);
        tick();
        chk("br.PC_F", bus.PC_F, 32'hC);
        chk_ifid("br.bubble", 32'h0, 32'h0, 32'h0, 1'b0);
        ctrl(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("br.next.PC_F", bus.PC_F, 32'h10);
        chk_ifid("br.target", 32'h44, 32'hC, 32'h10, 1'b1);

        // Redirect wins over stall; IF/ID holds.
        ctrl(1'b1, 1'b0, 1'b1, 32'h4);
        tick();
        chk("prio_a.PC_F", bus.PC_F, 32'h4);
        chk_ifid("prio_a", 32'h44, 32'hC, 32'h10, 1'b1);
        // Flush wins over stall; PC holds.
        ctrl(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        chk("prio_b.PC_F", bus.PC_F, 32'h4);
        chk_ifid("prio_b", 32'h0, 32'h0, 32'h0, 1'b0);
        ctrl(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("prio_b.next.PC_F", bus.PC_F, 32'h8);
        chk_ifid("prio_b.next", 32'h22, 32'h4, 32'h8, 1'b1);

        // Index wrap: 0x100 maps to word 0, rewritten to 0xAA in the redirect cycle.
        ctrl(1'b0, 1'b1, 1'b1, 32'h100);
        bus.imem_we    = 1'b1;
        bus.imem_waddr = 6'd0;
        bus.imem_wdata = 32'hAA;
        tick();
        bus.imem_we = 1'b0;
        chk("wrap_a.PC_F", bus.PC_F, 32'h100);
        ctrl(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        chk_ifid("wrap_a", 32'hAA, 32'h100, 32'h104, 1'b1);

        // PC wraps past 0xFFFF_FFFC.
        ctrl(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        tick();
        chk("wrap_b.PC_F", bus.PC_F, 32'hFFFF_FFFC);
        ctrl(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("wrap_b.next.PC_F", bus.PC_F, 32'h0);
        chk_ifid("wrap_b", 32'hEE, 32'hFFFF_FFFC, 32'h0, 1'b1);
        tick();
        chk_ifid("wrap_b.after", 32'hAA, 32'h0, 32'h4, 1'b1);

        // Same-cycle write to the word being fetched returns the old value.
        bus.imem_we    = 1'b1;
        bus.imem_waddr = 6'd1;
        bus.imem_wdata = 32'h99;
        tick();
        bus.imem_we = 1'b0;
        chk_ifid("rdw.old", 32'h22, 32'h4, 32'h8, 1'b1);
        ctrl(1'b0, 1'b1, 1'b1, 32'h4);
        tick();
        ctrl(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        chk_ifid("rdw.new", 32'h99, 32'h4, 32'h8, 1'b1);
        tick();
        tick();
        chk("pre_rst.PC_F", bus.PC_F, 32'h10);
        chk_ifid("pre_rst", 32'h44, 32'hC, 32'h10, 1'b1);

        // Asynchronous reset between edges.
        #3 rst = 1'b0;
        #1;
        chk("async.PC_F", bus.PC_F, 32'h0);
        chk_ifid("async", 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        chk("async.hold.PC_F", bus.PC_F, 32'h0);
        rst = 1'b1;
        tick();
        chk("restart.PC_F", bus.PC_F, 32'h4);
        chk_ifid("restart0", 32'hAA, 32'h0, 32'h4, 1'b1);
        tick();
        chk_ifid("restart1", 32'h99, 32'h4, 32'h8, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch (F) stage of the 5-stage pipeline. It sits directly upstream of the decode stage.
- Holds the program counter and a word-addressed instruction memory.
- Drives the IF/ID pipeline register that feeds decode (Instr_D, PC_D, PC_plus4_D, valid_D).
- Supports stall, flush and taken-branch redirect from execute.
- Has a bench/boot load port for preloading the instruction memory.

Parameters:
ADDR_W, 32, PC and address width
DATA_W, 32, instruction width
IMEM_DEPTH, 64, instruction memory depth in words (power of 2)
RESET_PC, 32'h0000_0000, PC value after reset
NOP_INSTR, 32'h0000_0000, bubble instruction inserted on flush/reset

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
stall_F  input  1  hold PC and IF/ID register
flush_D  input  1  replace IF/ID contents with bubble
pc_src_E  input  1  taken branch/jump redirect from execute
pc_target_E  input  ADDR_W  redirect target address
imem_we  input  1  instruction memory write enable (load port)
imem_waddr  input  $clog2(IMEM_DEPTH)  word address for load
imem_wdata  input  DATA_W  word to load
PC_F  output  ADDR_W  current fetch PC
Instr_D  output  DATA_W  registered instruction to decode
PC_D  output  ADDR_W  registered PC of Instr_D
PC_plus4_D  output  ADDR_W  registered PC_D+4
valid_D  output  1  1 = Instr_D is a real fetched instruction

Behaviour:
- Reset (rst=0, asynchronous, takes effect without a clock edge):
  - PC_F=RESET_PC, Instr_D=NOP_INSTR, PC_D=0, PC_plus4_D=0, valid_D=0.
  - Memory contents are not cleared.
  - Deassertion is sampled at the next rising edge; the first fetch of RESET_PC happens then.
- Instruction read:
  - instr_F = imem[(PC_F>>2) mod IMEM_DEPTH], combinational.
  - PC_F[1:0] is ignored.
  - Address wraps modulo IMEM_DEPTH words; no out-of-range error.
- Next-PC select, priority order:
  1. pc_src_E=1 -> PC_F <= {pc_target_E[ADDR_W-1:2],2'b00}. Redirect overrides stall.
  2. stall_F=1 -> PC_F holds.
  3. Otherwise -> PC_F <= PC_F+4, modulo 2^ADDR_W (0xFFFF_FFFC wraps to 0).
- IF/ID register update, priority order:
  1. flush_D=1 -> Instr_D<=NOP_INSTR, PC_D<=0, PC_plus4_D<=0, valid_D<=0. Flush overrides stall.
  2. stall_F=1 -> all IF/ID outputs hold.
  3. Otherwise -> Instr_D<=instr_F, PC_D<=PC_F, PC_plus4_D<=PC_F+4, valid_D<=1.
- Latency: the instruction at address A appears on Instr_D one cycle after the cycle in which PC_F=A and no stall or flush is active.
- Simultaneous events:
  - flush_D+stall_F: IF/ID becomes a bubble; PC holds (unless pc_src_E).
  - pc_src_E+flush_D in the same cycle (normal branch-taken case): PC loads the target and IF/ID becomes a bubble; the target instruction appears on Instr_D one cycle later.
- Load port:
  - imem[imem_waddr] <= imem_wdata on a rising edge when imem_we=1.
  - Writes are honoured regardless of rst, so preload is allowed while reset is held.
  - A same-cycle read of the address being written returns the old word; the new word is visible from the next cycle.
- Reset mid-operation: all registers return to their reset values immediately; memory contents are kept.
- No X propagation: every output is defined from reset onward.

Test Plan:
1. Reset and sequential fetch:
   - Stimulus: hold rst=0, preload imem[0..3]=0x11,0x22,0x33,0x44, then release rst.
   - Required response: valid_D=0 and Instr_D=0 during reset. Then, on successive cycles: Instr_D=0x11/PC_D=0, 0x22/PC_D=4, 0x33/PC_D=8 with PC_plus4_D=0x0C, all with valid_D=1.
2. Stall:
   - Stimulus: assert stall_F for 2 cycles while PC_F=8.
   - Required response: PC_F stays 8; Instr_D/PC_D hold 0x22/4; fetch resumes with 0x33 after release.
3. Branch redirect:
   - Stimulus: pc_src_E=1, flush_D=1, pc_target_E=0x0000_000E (misaligned).
   - Required response: next PC_F=0x0C; next Instr_D=NOP with valid_D=0; following cycle Instr_D=0x44, PC_D=0x0C.
4. Priority:
   - Stimulus (a): stall_F=1 with pc_src_E=1, target 0x4.
   - Required response (a): PC_F=0x4 (redirect wins).
   - Stimulus (b): stall_F=1 with flush_D=1.
   - Required response (b): valid_D=0 and PC_F holds.
5. Wrap-around:
   - Stimulus (a): IMEM_DEPTH=64, imem[0]=0xAA, redirect to 0x100.
   - Required response (a): Instr_D=0xAA, PC_D=0x100.
   - Stimulus (b): redirect to 0xFFFF_FFFC.
   - Required response (b): next PC_F=0x0.
6. Async reset mid-run:
   - Stimulus: drop rst between clock edges while PC_F=0x10.
   - Required response: PC_F=0 and valid_D=0 before the next edge; imem contents unchanged; after release, fetch restarts at imem[0].
